mp3_player_ctrl: RTL and testbench

- Front-panel control stage directly upstream of the MP3 decoder driver.
- Debounces five push-buttons (next, prev, vol+, vol-, pause) and turns them into player state.
- Produces SongNow, MusicSize, VOLUME and IS_SUSPENDING, which the decoder driver consumes unchanged.
- Runs on the decoder's serial clock domain, so its outputs need no synchroniser.

---
 rtl/mp3_player_ctrl_pkg.sv | 42 ++++
 rtl/mp3_player_ctrl_if.sv | 22 ++
 rtl/mp3_player_ctrl_btn_debounce.sv | 56 +++++
 rtl/mp3_player_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mp3_player_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mp3_player_ctrl_pkg.sv
// Shared constants and helpers for the MP3 front-panel controller:
// event codes, button indices, repeat-FSM states and VS1003 volume math.
package mp3_player_ctrl_pkg;

  // VS1003 attenuation byte: 0 is loudest, 0xFE is the quietest usable value.
  localparam logic [7:0] VOL_MAX  = 8'hFE;
  localparam logic [7:0] VOL_INIT = 8'h20;

  // Arbitrated events. A lower numeric code means a higher priority.
  localparam logic [2:0] EV_NONE  = 3'd0;
  localparam logic [2:0] EV_NEXT  = 3'd1;
  localparam logic [2:0] EV_PREV  = 3'd2;
  localparam logic [2:0] EV_PAUSE = 3'd3;
  localparam logic [2:0] EV_VUP   = 3'd4;
  localparam logic [2:0] EV_VDN   = 3'd5;

  localparam int B_NEXT  = 0;
  localparam int B_PREV  = 1;
  localparam int B_PAUSE = 2;
  localparam int B_VUP   = 3;
  localparam int B_VDN   = 4;
  localparam int NUM_BTN = 5;

  typedef enum logic [2:0] {
    RS_IDLE   = 3'b001,
    RS_WAIT   = 3'b010,
    RS_REPEAT = 3'b100
  } rep_state_e;

  function automatic logic [7:0] vol_louder(input logic [7:0] vol, input logic [7:0] step);
    return (vol < step) ? 8'h00 : vol - step;
  endfunction

  // The sum is formed in 9 bits so a step near the top cannot wrap past 0xFF.
  function automatic logic [7:0] vol_quieter(input logic [7:0] vol, input logic [7:0] step,
                                             input logic [7:0] max);
    logic [8:0] sum;
    sum = {1'b0, vol} + {1'b0, step};
    return (sum > {1'b0, max}) ? max : sum[7:0];
  endfunction

endpackage

// File: rtl/mp3_player_ctrl_if.sv
// Front panel (raw buttons) and decoder-driver (player state) signals of the controller.
interface mp3_player_ctrl_if;
  logic        BTN_NEXT;
  logic        BTN_PREV;
  logic        BTN_VOL_UP;
  logic        BTN_VOL_DN;
  logic        BTN_PAUSE;
  logic [31:0] SongNow;
  logic [31:0] MusicSize;
  logic [7:0]  VOLUME;
  logic        IS_SUSPENDING;

  modport slave (
    input  BTN_NEXT, BTN_PREV, BTN_VOL_UP, BTN_VOL_DN, BTN_PAUSE,
    output SongNow, MusicSize, VOLUME, IS_SUSPENDING
  );

  modport master (
    output BTN_NEXT, BTN_PREV, BTN_VOL_UP, BTN_VOL_DN, BTN_PAUSE,
    input  SongNow, MusicSize, VOLUME, IS_SUSPENDING
  );
endinterface

// File: rtl/mp3_player_ctrl_btn_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, accepted level and
// a single-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make the synchroniser a true two-stage shift.
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/mp3_player_ctrl.sv
// MP3 front-panel controller: debounced buttons, volume auto-repeat, priority
// arbitration and the registered player state consumed by the decoder driver.
module mp3_player_ctrl #(
  parameter int                      NUM_SONGS       = 4,
  parameter logic [NUM_SONGS*32-1:0] SONG_SIZES      = {4{32'd4096}},
  parameter int                      DEBOUNCE_CYCLES = 20000,
  parameter int                      VOL_STEP        = 8,
  parameter logic [7:0]              VOL_MAX         = mp3_player_ctrl_pkg::VOL_MAX,
  parameter logic [7:0]              VOL_INIT        = mp3_player_ctrl_pkg::VOL_INIT,
  parameter int                      REPEAT_DELAY    = 500000,
  parameter int                      REPEAT_PERIOD   = 100000
) (
  input logic              CLK,
  input logic              RESET_N,
  mp3_player_ctrl_if.slave bus
);
  import mp3_player_ctrl_pkg::*;

  localparam int                SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [7:0]        STEP8     = 8'(VOL_STEP);
  localparam int                RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int                RW        = $clog2(RMAX + 1) + 1;
  localparam logic [RW-1:0]     DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]     PER_LAST  = RW'(REPEAT_PERIOD - 1);

  function automatic logic [31:0] size_of(input logic [SONG_W-1:0] idx);
    return SONG_SIZES[32*int'(idx) +: 32];
  endfunction

  logic [NUM_BTN-1:0] raw, lvl, prs;

  assign raw[B_NEXT]  = bus.BTN_NEXT;
  assign raw[B_PREV]  = bus.BTN_PREV;
  assign raw[B_PAUSE] = bus.BTN_PAUSE;
  assign raw[B_VUP]   = bus.BTN_VOL_UP;
  assign raw[B_VDN]   = bus.BTN_VOL_DN;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .btn_raw (raw[i]),
      .level   (lvl[i]),
      .press   (prs[i])
    );
  end

  // Only the volume buttons care about the held level.
  logic unused_lvl;
  assign unused_lvl = ^lvl[B_PAUSE:B_NEXT];

  // Volume auto-repeat, index 0 = vol_up, 1 = vol_dn. The counter starts at 1 on
  // the press so it counts cycles since the press pulse.
  logic [1:0]    vol_press, vol_lvl, rep_ev_q;
  rep_state_e    rep_state_q [2];
  logic [RW-1:0] rep_cnt_q   [2];

  assign vol_press = {prs[B_VDN], prs[B_VUP]};
  assign vol_lvl   = {lvl[B_VDN], lvl[B_VUP]};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rep_ev_q <= '0;
      for (int j = 0; j < 2; j++) begin
        rep_state_q[j] <= RS_IDLE;
        rep_cnt_q[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        rep_ev_q[j] <= 1'b0;
        unique case (rep_state_q[j])
          RS_IDLE: begin
            if (vol_press[j]) begin
              rep_state_q[j] <= RS_WAIT;
              rep_cnt_q[j]   <= RW'(1);
            end
          end
          RS_WAIT: begin
            if (!vol_lvl[j]) begin
              rep_state_q[j] <= RS_IDLE;
              rep_cnt_q[j]   <= '0;
            end else if (rep_cnt_q[j] == DLY_LAST) begin
              rep_state_q[j] <= RS_REPEAT;
              rep_cnt_q[j]   <= '0;
              rep_ev_q[j]    <= 1'b1;
            end else begin
              rep_cnt_q[j] <= rep_cnt_q[j] + RW'(1);
            end
          end
          RS_REPEAT: begin
            if (!vol_lvl[j]) begin
              rep_state_q[j] <= RS_IDLE;
              rep_cnt_q[j]   <= '0;
            end else if (rep_cnt_q[j] == PER_LAST) begin
              rep_cnt_q[j] <= '0;
              rep_ev_q[j]  <= 1'b1;
            end else begin
              rep_cnt_q[j] <= rep_cnt_q[j] + RW'(1);
            end
          end
          default: begin
            rep_state_q[j] <= RS_IDLE;
            rep_cnt_q[j]   <= '0;
          end
        endcase
      end
    end
  end

  // Fixed-priority arbiter; losing events are dropped, never queued.
  logic [2:0] ev_sel;

  always_comb begin
    ev_sel = EV_NONE;
    if      (prs[B_NEXT])                ev_sel = EV_NEXT;
    else if (prs[B_PREV])                ev_sel = EV_PREV;
    else if (prs[B_PAUSE])               ev_sel = EV_PAUSE;
    else if (prs[B_VUP] || rep_ev_q[0])  ev_sel = EV_VUP;
    else if (prs[B_VDN] || rep_ev_q[1])  ev_sel = EV_VDN;
  end

  logic [SONG_W-1:0] song_q, song_d;
  logic [31:0]       size_q, size_d;
  logic [7:0]        vol_q, vol_d;
  logic              susp_q, susp_d;

  always_comb begin
    song_d = song_q;
    size_d = size_q;
    vol_d  = vol_q;
    susp_d = susp_q;
    unique case (ev_sel)
      EV_NEXT: begin
        song_d = (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);
        size_d = size_of(song_d);
        susp_d = 1'b0;
      end
      EV_PREV: begin
        song_d = (song_q == '0) ? LAST_SONG : song_q - SONG_W'(1);
        size_d = size_of(song_d);
        susp_d = 1'b0;
      end
      EV_PAUSE: susp_d = ~susp_q;
      EV_VUP:   vol_d  = vol_louder(vol_q, STEP8);
      EV_VDN:   vol_d  = vol_quieter(vol_q, STEP8, VOL_MAX);
      default:  ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      song_q <= '0;
      size_q <= SONG_SIZES[31:0];
      vol_q  <= VOL_INIT;
      susp_q <= 1'b0;
    end else begin
      song_q <= song_d;
      size_q <= size_d;
      vol_q  <= vol_d;
      susp_q <= susp_d;
    end
  end

  assign bus.SongNow       = 32'(song_q);
  assign bus.MusicSize     = size_q;
  assign bus.VOLUME        = vol_q;
  assign bus.IS_SUSPENDING = susp_q;

endmodule

// File: tb/tb_mp3_player_ctrl.sv
// Self-checking bench for mp3_player_ctrl: directed steps plus random presses,
// compared every cycle against an event-level model of the player.
module tb_mp3_player_ctrl;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 5;
  localparam int NS   = 3;
  localparam int STEP = 8;
  localparam int VMAX = 254;
  localparam int VINI = 32;
  // Ticks from driving a raw button to the output update: 2 sync + DEB stable + 1 register.
  localparam int LAT  = 2 + DEB + 1;

  logic clk;
  logic rst_n;

  mp3_player_ctrl_if bus ();

  mp3_player_ctrl #(
    .NUM_SONGS       (NS),
    .SONG_SIZES      ({32'd100, 32'd200, 32'd300}),
    .DEBOUNCE_CYCLES (DEB),
    .VOL_STEP        (STEP),
    .VOL_MAX         (8'hFE),
    .VOL_INIT        (8'h20),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  int m_song, m_vol, m_susp;
  int size_tab [NS] = '{300, 200, 100};

  task automatic model_reset();
    m_song = 0;
    m_vol  = VINI;
    m_susp = 0;
  endtask

  // Button index b: 0 next, 1 prev, 2 pause, 3 vol_up, 4 vol_dn.
  task automatic apply_event(input int b);
    case (b)
      0: begin m_song = (m_song + 1) % NS;      m_susp = 0; end
      1: begin m_song = (m_song + NS - 1) % NS; m_susp = 0; end
      2: m_susp = 1 - m_susp;
      3: m_vol = (m_vol < STEP) ? 0 : m_vol - STEP;
      4: m_vol = (m_vol + STEP > VMAX) ? VMAX : m_vol + STEP;
      default: ;
    endcase
  endtask

  // Volume events seen by tick k of an uninterrupted hold.
  function automatic int events_by(input int k);
    if (k < LAT)        return 0;
    if (k < LAT + RDLY) return 1;
    return 2 + (k - LAT - RDLY) / RPER;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".song"}, bus.SongNow,              32'(m_song));
    check({tag, ".size"}, bus.MusicSize,            32'(size_tab[m_song]));
    check({tag, ".vol"},  32'(bus.VOLUME),          32'(m_vol));
    check({tag, ".susp"}, 32'(bus.IS_SUSPENDING),   32'(m_susp));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [4:0] mask);
    bus.BTN_NEXT   = mask[0];
    bus.BTN_PREV   = mask[1];
    bus.BTN_PAUSE  = mask[2];
    bus.BTN_VOL_UP = mask[3];
    bus.BTN_VOL_DN = mask[4];
  endtask

  // Press the buttons in mask for hold ticks (hold <= 12, below the repeat delay),
  // checking every tick; the highest-priority button acts once at tick LAT.
  task automatic press(input string tag, input logic [4:0] mask, input int hold);
    set_btns(mask);
    for (int k = 1; k <= hold + 15; k++) begin
      tick(1);
      if (k == hold) set_btns(5'b0);
      if (k == LAT && hold >= DEB) begin
        for (int i = 0; i < 5; i++) begin
          if (mask[i]) begin
            apply_event(i);
            break;
          end
        end
      end
      check_all(tag);
    end
  endtask

  // Hold one volume button for n ticks, checking the auto-repeat cadence.
  task automatic hold_vol(input string tag, input int b, input int n);
    int applied;
    applied = 0;
    set_btns(5'(1 << b));
    for (int k = 1; k <= n; k++) begin
      tick(1);
      while (applied < events_by(k)) begin
        apply_event(b);
        applied++;
      end
      check_all(tag);
    end
    set_btns(5'b0);
    tick(20);
    check_all({tag, ".after"});
  endtask

  initial begin
    rst_n = 1'b0;
    set_btns(5'b0);
    model_reset();
    tick(3);
    check_all("in_reset");
    rst_n = 1'b1;
    tick(2);
    check_all("after_reset");

    // Short glitch is rejected, then a real hold advances exactly once at LAT.
    press("glitch", 5'b00001, 3);
    press("next_1", 5'b00001, 10);
    press("next_2", 5'b00001, 6);
    press("next_wrap", 5'b00001, 6);
    press("prev_wrap", 5'b00010, 6);

    press("pause_on", 5'b00100, 6);
    press("next_unpause", 5'b00001, 6);
    press("next_pause_same", 5'b00101, 6);

    hold_vol("vup_hold", 3, 60);
    hold_vol("vdn_hold", 4, 200);

    for (int r = 0; r < 25; r++) begin
      logic [4:0] mask;
      int hold;
      mask = 5'($urandom_range(1, 31));
      hold = $urandom_range(1, 12);
      press("rand", mask, hold);
    end

    // Reset mid-hold: asynchronous return to reset values, no stale event later.
    set_btns(5'b01000);
    tick(30);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    set_btns(5'b0);
    tick(5);
    check_all("held_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      check_all("post_reset_quiet");
    end
    press("fresh_next", 5'b00001, 6);

    if (fail_cnt != 0) $display("%0d comparisons did not match", fail_cnt);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
